// File: rtl/hbbus_pkg.sv
// Shared bus constants for the hex word printer: type codes, header characters,
// newline, and small helpers for header selection and leading-digit position.
package hbbus_pkg;

  localparam logic [1:0] TC_READ = 2'b00;
  localparam logic [1:0] TC_ACK  = 2'b01;
  localparam logic [1:0] TC_ADDR = 2'b10;
  localparam logic [1:0] TC_INT  = 2'b11;

  localparam logic [7:0] HDR_R  = 8'h52;
  localparam logic [7:0] HDR_K  = 8'h4B;
  localparam logic [7:0] HDR_A  = 8'h41;
  localparam logic [7:0] HDR_I  = 8'h49;
  localparam logic [7:0] HDR_E  = 8'h45;
  localparam logic [7:0] CH_NL  = 8'h0A;

  typedef struct packed {
    logic [1:0]  tc;
    logic [31:0] payload;
  } hb_word_t;

  function automatic logic [7:0] header_char(input logic [1:0] tc, input logic pl0);
    logic [7:0] c;
    case (tc)
      TC_READ: c = HDR_R;
      TC_ACK:  c = HDR_K;
      TC_ADDR: c = HDR_A;
      default: c = pl0 ? HDR_E : HDR_I;
    endcase
    return c;
  endfunction

  function automatic logic has_digits(input logic [1:0] tc);
    return (tc == TC_READ) || (tc == TC_ADDR);
  endfunction

  // Index of the most significant non-zero nibble; 0 for a zero payload so one digit prints.
  function automatic logic [2:0] top_nibble(input logic [31:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hbhexchar.sv
// Combinational nibble to lowercase ASCII hex digit.
module hbhexchar (
  input  logic [3:0] i_nib,
  output logic [7:0] o_char
);

  always_comb begin
    if (i_nib < 4'd10) o_char = 8'h30 + {4'h0, i_nib};
    else               o_char = 8'h57 + {4'h0, i_nib};
  end

endmodule

// File: rtl/hbwordhex.sv
// Converts 34-bit bus words into an ASCII header plus hex payload stream.
// Define HBWORDHEX_NEWLINE_EN to terminate every word with a newline.
module hbwordhex
  import hbbus_pkg::*;
#(
  parameter int DW = 34
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stb,
  input  logic [DW-1:0] i_word,
  output logic          o_busy,
  output logic          o_stb,
  output logic [7:0]    o_char,
  input  logic          i_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HDR   = 2'd1;
  localparam logic [1:0] S_DIGIT = 2'd2;
  localparam logic [1:0] S_NL    = 2'd3;

`ifdef HBWORDHEX_NEWLINE_EN
  localparam logic NL_EN = 1'b1;
`else
  localparam logic NL_EN = 1'b0;
`endif

  logic [1:0] state_q, state_d;
  hb_word_t   word_q, word_d;
  logic [2:0] cnt_q, cnt_d;

  logic       take;
  logic       last_char;
  logic       accept;
  logic [3:0] nib;
  logic [7:0] hex_char;

  assign nib = word_q.payload[{cnt_q, 2'b00} +: 4];

  hbhexchar u_hex (
    .i_nib  (nib),
    .o_char (hex_char)
  );

  always_comb begin
    o_stb     = (state_q != S_IDLE);
    take      = o_stb && !i_busy;
    last_char = 1'b0;
    o_char    = 8'h00;
    case (state_q)
      S_HDR: begin
        o_char    = header_char(word_q.tc, word_q.payload[0]);
        last_char = !has_digits(word_q.tc) && !NL_EN;
      end
      S_DIGIT: begin
        o_char    = hex_char;
        last_char = (cnt_q == 3'd0) && !NL_EN;
      end
      S_NL: begin
        o_char    = CH_NL;
        last_char = 1'b1;
      end
      default: ;
    endcase
    // Releasing busy on the final take lets the next word's header follow with no gap.
    o_busy = o_stb && !(take && last_char);
    accept = i_stb && !o_busy;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    if (take) begin
      case (state_q)
        S_HDR: begin
          if (has_digits(word_q.tc)) state_d = S_DIGIT;
          else if (NL_EN)            state_d = S_NL;
          else                       state_d = S_IDLE;
        end
        S_DIGIT: begin
          if (cnt_q != 3'd0) cnt_d   = cnt_q - 3'd1;
          else if (NL_EN)    state_d = S_NL;
          else               state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (accept) begin
      word_d  = hb_word_t'(i_word);
      cnt_d   = top_nibble(i_word[31:0]);
      state_d = S_HDR;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/hbwordhex.md
HBWORDHEX -- requirements
Module: hbwordhex

Interface
REQ-001 SHALL have parameter DW, default 34, meaning input word width (2-bit type code plus 32-bit payload); only 34 is supported.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_stb, input, 1, upstream word valid.
REQ-005 SHALL have port i_word, input, DW, upstream word: [33:32] type code, [31:0] payload.
REQ-006 SHALL have port o_busy, output, 1, meaning a word offered with i_stb is not accepted this cycle.
REQ-007 SHALL have port o_stb, output, 1, downstream character valid.
REQ-008 SHALL have port o_char, output, 8, ASCII character to the downstream byte buffer.
REQ-009 SHALL have port i_busy, input, 1, downstream stall.

Function
REQ-010 SHALL accept a word on any edge where i_stb && !o_busy, latching i_word internally.
REQ-011 SHALL drive o_busy high from the accept edge until the edge on which the final character of that word is taken (o_stb && !i_busy); it is low in IDLE.
REQ-012 SHALL implement states IDLE, HDR, DIGIT, NL: IDLE->HDR on accept; HDR->DIGIT or ->NL/IDLE when the header is taken; DIGIT loops until the last digit is taken; NL->IDLE when the newline is taken.
REQ-013 SHALL present the header character on the cycle after accept (one-cycle latency), with o_stb=1.
REQ-014 SHALL map type codes to headers: 00->'R' (8'h52), 01->'K' (8'h4B), 10->'A' (8'h41), 11 with payload[0]=0->'I' (8'h49), 11 with payload[0]=1->'E' (8'h45).
REQ-015 SHALL emit payload hex digits only for 'R' and 'A'; 'K', 'I' and 'E' words are header-only.
REQ-016 SHALL emit digits most-significant nibble first, as lowercase ASCII: '0'-'9', 'a'-'f'.
REQ-017 SHALL suppress leading zero nibbles, always emitting at least one digit; payload 0 emits the single digit '0'.
REQ-018 SHALL hold o_stb and o_char stable while o_stb && i_busy, advancing to the next character only on o_stb && !i_busy.
REQ-019 SHALL sustain one character per cycle when i_busy stays low; back-to-back words incur no bubble between the last character of one word and the header of the next.
REQ-020 SHALL ignore i_word changes after acceptance; upstream holds i_stb and i_word stable while o_busy is high.
REQ-021 SHALL drop o_stb to 0 in IDLE.

Reset
REQ-022 SHALL, on i_reset, force state IDLE, o_stb=0, o_char=8'h00, o_busy=0, and the digit counter to 0.
REQ-023 SHALL abandon any partly emitted word on reset mid-sequence, emitting no further characters of it.
REQ-024 SHALL give i_reset priority over a simultaneous accept: the word offered on the reset edge is discarded.

Configuration
REQ-025 SHALL, with HBWORDHEX_NEWLINE_EN defined, append a newline character (8'h0A) after the last character of every word via state NL.
REQ-026 SHALL, without HBWORDHEX_NEWLINE_EN, never enter NL and return to IDLE directly after the last character.

Structure
REQ-027 SHALL take header characters, the newline constant and type-code values from a shared package hbbus_pkg.
REQ-028 SHALL put nibble-to-ASCII conversion in one combinational sub-module hbhexchar (4-bit in, 8-bit out).

Verification
REQ-029 SHALL check: i_word={2'b00,32'h0000_1a2f}, i_busy=0 -> o_char 'R','1','a','2','f' on consecutive cycles, with o_busy low on the edge the 'f' is taken.
REQ-030 SHALL check: i_word={2'b10,32'h0} -> 'A','0'; and i_word={2'b01,32'hdead_beef} -> 'K' only.
REQ-031 SHALL check: i_word={2'b11,32'h1} -> 'E', and {2'b11,32'h0} -> 'I'.
REQ-032 SHALL check: 'R' word 32'hffff_ffff with i_busy held high for 3 cycles during the third digit -> o_char 'f' held stable with o_stb high throughout, then nine characters total.
REQ-033 SHALL check: reset asserted while the second digit of 32'h1234_5678 is presented -> next cycle o_stb=0 and o_busy=0, with no '3'-'8' emitted afterwards.
REQ-034 SHALL check, with HBWORDHEX_NEWLINE_EN: two back-to-back 'K' words -> 'K',8'h0A,'K',8'h0A on four consecutive cycles.
